patch_addr_gen: RTL and testbench
=================================

PATCH_ADDR_GEN -- requirements
Module: patch_addr_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- IMG_W, 28, image width in pixels.
- IMG_H, 28, image height in pixels.
REQ-002 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low. The ports (name, direction, width, meaning) SHALL be:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  begin a full-image scan; sampled in IDLE only.
- patch_ready  input  1  downstream accepts the current patch.
- pixel_addr0..pixel_addr8  output  10 each  registered image_mem addresses for the 3x3 window, row-major.
- load  output  1  window latch strobe.
- load_full_patch  output  1  with load: 1 = latch all nine pixels, 0 = shift rows up and latch bottom row only.
- patch_valid  output  1  latched patch is stable and presented downstream.
- out_row  output  5  output-map row of the current patch.
- out_col  output  5  output-map column of the current patch.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse when the scan completes.

Function
REQ-003 The scan SHALL be column-major with stride 1 and no padding: out_col 0..IMG_W-3 (outer loop), out_row 0..IMG_H-3 (inner loop). With the defaults this gives 26x26 = 676 patches.
REQ-004 The window base address SHALL be base = out_row*IMG_W + out_col. Each output pixel_addrK SHALL equal base + (K/3)*IMG_W + (K mod 3), using integer division. The maximum address with the defaults is 783.
REQ-005 The FSM SHALL have the states IDLE, ISSUE, LOAD, VALID and DONE.
REQ-006 IDLE: busy=0. If start=1, the FSM SHALL clear out_row and out_col and go to ISSUE.
REQ-007 ISSUE: all nine addresses SHALL be driven for the current (out_row, out_col), load=0, and the FSM SHALL go to LOAD next cycle. This cycle absorbs the one-cycle synchronous read latency of image_mem.
REQ-008 LOAD: the addresses SHALL be held unchanged and load=1. load_full_patch SHALL be 1 when out_row==0 and 0 otherwise. The FSM SHALL go to VALID.
REQ-009 VALID: patch_valid=1, addresses held, load=0. While patch_ready=0 the FSM SHALL stay in VALID; no further load SHALL be issued (backpressure).
REQ-010 VALID with patch_ready=1 (handshake) SHALL advance the counters:
- If out_row < IMG_H-3: out_row+1, and the FSM goes to ISSUE.
- Else if out_col < IMG_W-3: out_row=0, out_col+1, and the FSM goes to ISSUE (a full reload follows).
- Else: the FSM goes to DONE.
REQ-011 DONE: done=1 for exactly one cycle, busy=0, and the FSM SHALL go to IDLE.
REQ-012 busy SHALL be 1 in ISSUE, LOAD and VALID.
REQ-013 start asserted outside IDLE SHALL be ignored. start held high through DONE SHALL begin a new scan from IDLE on the following cycle.
REQ-014 A patch SHALL take a minimum of 3 cycles: start sampled in cycle 0 gives ISSUE in cycle 1, load in cycle 2, and patch_valid in cycle 3.
REQ-015 load and patch_valid SHALL never be asserted in the same cycle.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 When rst=0 the block SHALL asynchronously enter IDLE, including mid-scan. No pending patch or done pulse SHALL be produced after reset.
REQ-018 Reset values of all outputs SHALL be 0: all pixel_addr, load, load_full_patch, patch_valid, out_row, out_col, busy and done.
REQ-019 After rst returns to 1, the block SHALL remain in IDLE until start is sampled high.

Verification
REQ-020 Reset and first patch: assert rst=0, then pulse start. Required response:
- While rst=0, all outputs read 0.
- Cycle 1: addresses 0,1,2,28,29,30,56,57,58.
- Cycle 2: load=1, load_full_patch=1.
- Cycle 3: patch_valid=1 with out_row=0, out_col=0.
REQ-021 Row slide: handshake patch (0,0). Required response: the next patch is (1,0) with addresses 28..30, 56..58, 84..86, load_full_patch=0 on its load cycle.
REQ-022 Column wrap: handshake patch (25,0). Required response: the next patch is (0,1) with pixel_addr0=1, pixel_addr8=59, load_full_patch=1.
REQ-023 Backpressure: hold patch_ready=0 for 5 cycles in VALID. Required response: patch_valid stays 1, the addresses are stable, and load=0 throughout; the handshake occurs on the first cycle patch_ready=1.
REQ-024 Full scan: hold patch_ready=1. Required response:
- Exactly 676 handshakes.
- The last patch is (25,25) with pixel_addr0=725 and pixel_addr8=783.
- done pulses once, 1 cycle after the final handshake, and busy=0 thereafter.
REQ-025 Mid-scan reset and ignored start: drive rst=0 at patch (3,7), then release it and pulse start; separately, pulse start while busy. Required response:
- After the reset, all outputs read 0 immediately.
- The next scan restarts at (0,0).
- The start pulse while busy leaves the counters unaffected.

Source files
------------

// File: rtl/patch_addr_gen.sv
// 3x3 convolution window address generator: column-major stride-1 scan over an
// IMG_W x IMG_H image with a registered ISSUE/LOAD/VALID handshake per patch.
module patch_addr_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       patch_ready,
  output logic [9:0] pixel_addr0,
  output logic [9:0] pixel_addr1,
  output logic [9:0] pixel_addr2,
  output logic [9:0] pixel_addr3,
  output logic [9:0] pixel_addr4,
  output logic [9:0] pixel_addr5,
  output logic [9:0] pixel_addr6,
  output logic [9:0] pixel_addr7,
  output logic [9:0] pixel_addr8,
  output logic       load,
  output logic       load_full_patch,
  output logic       patch_valid,
  output logic [4:0] out_row,
  output logic [4:0] out_col,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    LOAD,
    VALID,
    DONE
  } state_t;

  state_t     state_q;
  logic [4:0] row_q, col_q;
  logic [4:0] row_d, col_d;
  logic [9:0] base_d;
  logic [9:0] addr_q [9];
  logic [9:0] addr_d [9];
  logic       load_q, full_q, valid_q, busy_q, done_q;
  logic       last_row, last_col;

  assign last_row = (row_q == 5'(IMG_H - 3));
  assign last_col = (col_q == 5'(IMG_W - 3));

  // Next window position: cleared when leaving IDLE, advanced on a VALID handshake.
  // Addresses are computed from these so they land in the same edge that enters ISSUE.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (state_q == IDLE) begin
      row_d = '0;
      col_d = '0;
    end else if (!last_row) begin
      row_d = row_q + 5'd1;
    end else begin
      row_d = '0;
      col_d = col_q + 5'd1;
    end
    base_d = 10'(row_d) * 10'(IMG_W) + 10'(col_d);
    for (int unsigned k = 0; k < 9; k++) begin
      addr_d[k] = base_d + 10'(k / 3) * 10'(IMG_W) + 10'(k % 3);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      load_q  <= 1'b0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned k = 0; k < 9; k++) addr_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          load_q  <= 1'b1;
          full_q  <= (row_q == '0);
          state_q <= LOAD;
        end
        LOAD: begin
          load_q  <= 1'b0;
          full_q  <= 1'b0;
          valid_q <= 1'b1;
          state_q <= VALID;
        end
        VALID: begin
          if (patch_ready) begin
            valid_q <= 1'b0;
            if (!last_row || !last_col) begin
              row_q   <= row_d;
              col_q   <= col_d;
              addr_q  <= addr_d;
              state_q <= ISSUE;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pixel_addr0     = addr_q[0];
  assign pixel_addr1     = addr_q[1];
  assign pixel_addr2     = addr_q[2];
  assign pixel_addr3     = addr_q[3];
  assign pixel_addr4     = addr_q[4];
  assign pixel_addr5     = addr_q[5];
  assign pixel_addr6     = addr_q[6];
  assign pixel_addr7     = addr_q[7];
  assign pixel_addr8     = addr_q[8];
  assign load            = load_q;
  assign load_full_patch = full_q;
  assign patch_valid     = valid_q;
  assign out_row         = row_q;
  assign out_col         = col_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_patch_addr_gen.sv
// Directed bench for patch_addr_gen: expected patches are queued as stimulus is
// driven and compared cycle-by-cycle through ISSUE, LOAD and VALID.
module tb_patch_addr_gen;

  localparam int W = 28;
  localparam int H = 28;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       patch_ready = 1'b0;
  logic [9:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic       load, lfp, pv, busy, done;
  logic [4:0] out_row, out_col;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int row;
    int col;
  } patch_t;

  patch_t sbq[$];
  int     m_row, m_col;

  always #5 clk = ~clk;

  patch_addr_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .patch_ready(patch_ready),
    .pixel_addr0(a0), .pixel_addr1(a1), .pixel_addr2(a2),
    .pixel_addr3(a3), .pixel_addr4(a4), .pixel_addr5(a5),
    .pixel_addr6(a6), .pixel_addr7(a7), .pixel_addr8(a8),
    .load(load), .load_full_patch(lfp), .patch_valid(pv),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
  );

  function automatic logic [31:0] dut_addr(int k);
    case (k)
      0: return 32'(a0);
      1: return 32'(a1);
      2: return 32'(a2);
      3: return 32'(a3);
      4: return 32'(a4);
      5: return 32'(a5);
      6: return 32'(a6);
      7: return 32'(a7);
      default: return 32'(a8);
    endcase
  endfunction

  function automatic int exp_addr(int r, int c, int k);
    return (r + k / 3) * W + c + k % 3;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string tag);
    check(tag, 32'(|{a0, a1, a2, a3, a4, a5, a6, a7, a8, load, lfp, pv,
                     out_row, out_col, busy, done}), 0);
  endtask

  // Called in the cycle just after the DUT entered ISSUE for the queued patch.
  task automatic run_patch();
    patch_t e;
    check("sb_size", sbq.size(), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check("issue_busy", busy, 1);
      check("issue_load", load, 0);
      check("issue_valid", pv, 0);
      for (int k = 0; k < 9; k++) check("issue_addr", dut_addr(k), exp_addr(e.row, e.col, k));
      step();
      check("load_strobe", load, 1);
      check("load_full", lfp, 32'(e.row == 0));
      check("load_valid", pv, 0);
      check("load_addr0", dut_addr(0), exp_addr(e.row, e.col, 0));
      check("load_addr8", dut_addr(8), exp_addr(e.row, e.col, 8));
      step();
      check("valid", pv, 1);
      check("valid_load", load, 0);
      check("valid_row", out_row, e.row);
      check("valid_col", out_col, e.col);
      for (int k = 0; k < 9; k++) check("valid_addr", dut_addr(k), exp_addr(e.row, e.col, k));
    end
  endtask

  task automatic handshake(output bit last);
    last = (m_row == H - 3) && (m_col == W - 3);
    if (!last) begin
      if (m_row < H - 3) m_row++;
      else begin
        m_row = 0;
        m_col++;
      end
      sbq.push_back('{m_row, m_col});
    end
    patch_ready = 1'b1;
    step();
    patch_ready = 1'b0;
  endtask

  task automatic start_scan();
    m_row = 0;
    m_col = 0;
    sbq.push_back('{0, 0});
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    bit last;
    int hs;
    int guard;

    #12;
    check_zero("reset_outputs");
    step();
    check_zero("reset_hold");
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    check("idle_busy", busy, 0);
    check("idle_valid", pv, 0);

    start_scan();
    run_patch();
    handshake(last);
    run_patch();

    // Backpressure on patch (1,0), with a start pulse that must be ignored.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      step();
      start = 1'b0;
      check("bp_valid", pv, 1);
      check("bp_load", load, 0);
      check("bp_busy", busy, 1);
      check("bp_addr0", dut_addr(0), exp_addr(1, 0, 0));
      check("bp_addr8", dut_addr(8), exp_addr(1, 0, 8));
    end
    handshake(last);
    run_patch();

    guard = 0;
    while (!(m_row == 3 && m_col == 7) && guard < 1000) begin
      handshake(last);
      run_patch();
      guard++;
    end
    check("reach_3_7", {out_row, out_col}, {5'd3, 5'd7});

    #2;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    step();
    check_zero("reset_mid_hold");
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_reset_idle", {busy, pv, load, done}, 0);
    end

    start_scan();
    run_patch();
    hs = 0;
    last = 1'b0;
    while (!last && hs < 1000) begin
      if (m_row == H - 3 && m_col == W - 3) begin
        check("last_addr0", dut_addr(0), 725);
        check("last_addr8", dut_addr(8), 783);
        check("last_rowcol", {out_row, out_col}, {5'd25, 5'd25});
      end
      handshake(last);
      hs++;
      if (!last) run_patch();
    end
    check("handshakes", hs, 676);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", pv, 0);
    check("done_load", load, 0);
    step();
    check("done_clear", done, 0);
    check("after_busy", busy, 0);
    step();
    check("done_once", done, 0);
    check("idle_valid_end", pv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
